// File: rtl/axis_core_wrapper.sv
// Buffers one AXI-Stream job for a parallel core, then streams results (plus optional status word) out.
// Result beats start one cycle after core_done; input stalls in PROC/SEND, output holds while m_axis_tready is low.
module axis_core_wrapper #(
    parameter int DATA_W    = 32,
    parameter int IN_WORDS  = 20,
    parameter int OUT_WORDS = 8,
    parameter int STATUS_EN = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic [DATA_W/8-1:0]           m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic                          core_start,
    output logic [IN_WORDS*DATA_W-1:0]    core_in,
    input  logic                          core_done,
    input  logic [OUT_WORDS*DATA_W-1:0]   core_out,
    output logic                          err_short,
    output logic                          err_long,
    output logic [7:0]                    err_count
);
    localparam int TOT  = OUT_WORDS + STATUS_EN;
    localparam int WI_W = $clog2(IN_WORDS);
    localparam int RP_W = (TOT > 1) ? $clog2(TOT) : 1;
    localparam logic [WI_W-1:0] WI_LAST = WI_W'(IN_WORDS - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(TOT - 1);

    typedef enum logic [2:0] {IDLE, RECV, DRAIN, PROC, SEND} state_t;

    state_t                     state_q, state_d;
    logic [WI_W-1:0]            wr_idx_q, wr_idx_d;
    logic [RP_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [15:0]                job_id_q, job_id_d;
    logic [7:0]                 err_count_q, err_count_d;
    logic                       long_flag_q, long_flag_d;
    logic                       core_start_q, core_start_d;
    logic                       err_short_q, err_short_d;
    logic                       err_long_q, err_long_d;
    logic [IN_WORDS*DATA_W-1:0] in_buf_q, in_buf_d;
    logic [DATA_W-1:0]          out_buf_q [TOT];
    logic [DATA_W-1:0]          out_buf_d [TOT];
    logic [DATA_W-1:0]          status_w;
    logic                       s_acc;
    logic                       m_hs;

    assign s_axis_tready = (state_q == IDLE) || (state_q == RECV) || (state_q == DRAIN);
    assign s_acc         = s_axis_tvalid && s_axis_tready;
    assign m_axis_tvalid = (state_q == SEND);
    assign m_axis_tlast  = m_axis_tvalid && (rd_ptr_q == RP_LAST);
    assign m_axis_tdata  = out_buf_q[rd_ptr_q];
    assign m_axis_tkeep  = '1;
    assign m_hs          = m_axis_tvalid && m_axis_tready;
    assign core_start    = core_start_q;
    assign core_in       = in_buf_q;
    assign err_short     = err_short_q;
    assign err_long      = err_long_q;
    assign err_count     = err_count_q;

    // job_id has already advanced on the start edge, so the running job is one behind.
    always_comb begin
        status_w        = '0;
        status_w[31:16] = job_id_q - 16'd1;
        status_w[0]     = long_flag_q;
    end

    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        rd_ptr_d     = rd_ptr_q;
        job_id_d     = job_id_q;
        err_count_d  = err_count_q;
        long_flag_d  = long_flag_q;
        core_start_d = 1'b0;
        err_short_d  = 1'b0;
        err_long_d   = 1'b0;
        in_buf_d     = in_buf_q;
        out_buf_d    = out_buf_q;

        case (state_q)
            IDLE, RECV: begin
                if (s_acc) begin
                    in_buf_d[(IN_WORDS - 1 - int'(wr_idx_q)) * DATA_W +: DATA_W] = s_axis_tdata;
                    if (wr_idx_q == WI_LAST) begin
                        wr_idx_d = '0;
                        if (s_axis_tlast) begin
                            state_d      = PROC;
                            core_start_d = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        wr_idx_d    = '0;
                        state_d     = IDLE;
                        err_short_d = 1'b1;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                        state_d  = RECV;
                    end
                end
            end
            DRAIN: begin
                if (s_acc && s_axis_tlast) begin
                    err_long_d   = 1'b1;
                    long_flag_d  = 1'b1;
                    state_d      = PROC;
                    core_start_d = 1'b1;
                end
            end
            PROC: begin
                if (core_done) begin
                    for (int i = 0; i < OUT_WORDS; i++) begin
                        out_buf_d[i] = core_out[(OUT_WORDS - 1 - i) * DATA_W +: DATA_W];
                    end
                    if (STATUS_EN != 0) begin
                        out_buf_d[TOT - 1] = status_w;
                    end
                    state_d = SEND;
                end
            end
            SEND: begin
                if (m_hs) begin
                    if (rd_ptr_q == RP_LAST) begin
                        rd_ptr_d    = '0;
                        long_flag_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (core_start_d) begin
            job_id_d = job_id_q + 16'd1;
        end
        if ((err_short_d || err_long_d) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_idx_q     <= '0;
            rd_ptr_q     <= '0;
            job_id_q     <= '0;
            err_count_q  <= '0;
            long_flag_q  <= 1'b0;
            core_start_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            rd_ptr_q     <= rd_ptr_d;
            job_id_q     <= job_id_d;
            err_count_q  <= err_count_d;
            long_flag_q  <= long_flag_d;
            core_start_q <= core_start_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
        end
    end

    // Data buffers keep their contents across reset.
    always_ff @(posedge clk) begin
        in_buf_q  <= in_buf_d;
        out_buf_q <= out_buf_d;
    end
endmodule

// File: tb/tb_axis_core_wrapper.sv
// Two wrappers (status word off / on) driven as a job source, a behavioural core and a result sink.
module tb_axis_core_wrapper;
    localparam int DW = 32;
    localparam int NI = 20;
    localparam int NO = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0]    s_tdata  [2];
    logic [1:0]       s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]    m_tdata  [2];
    logic [DW/8-1:0]  m_tkeep  [2];
    logic [1:0]       m_tvalid, m_tlast, m_tready;
    logic [1:0]       core_start, core_done, err_short, err_long;
    logic [NI*DW-1:0] core_in  [2];
    logic [NO*DW-1:0] core_out [2];
    logic [7:0]       err_count [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axis_core_wrapper #(.DATA_W(DW), .IN_WORDS(NI), .OUT_WORDS(NO), .STATUS_EN(g)) u_dut (
            .clk(clk), .reset(reset),
            .s_axis_tdata(s_tdata[g]), .s_axis_tvalid(s_tvalid[g]),
            .s_axis_tlast(s_tlast[g]), .s_axis_tready(s_tready[g]),
            .m_axis_tdata(m_tdata[g]), .m_axis_tkeep(m_tkeep[g]),
            .m_axis_tvalid(m_tvalid[g]), .m_axis_tlast(m_tlast[g]), .m_axis_tready(m_tready[g]),
            .core_start(core_start[g]), .core_in(core_in[g]),
            .core_done(core_done[g]), .core_out(core_out[g]),
            .err_short(err_short[g]), .err_long(err_long[g]), .err_count(err_count[g])
        );
    end

    int errors = 0;
    int checks = 0;
    int beats  [2];
    int starts [2];
    logic [32:0] q0 [$];
    logic [32:0] q1 [$];

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int d, input logic [31:0] v, input logic last);
        if (d == 0) q0.push_back({last, v});
        else        q1.push_back({last, v});
    endtask

    // One clock: score the handshake the coming edge will take, then settle at the falling edge.
    task automatic cyc();
        for (int d = 0; d < 2; d++) begin
            if (!reset && core_start[d]) starts[d]++;
            if (!reset && m_tvalid[d] && m_tready[d]) begin
                logic [32:0] e;
                beats[d]++;
                checks++;
                if (qsize(d) == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected dut%0d: got last=%b data=%h, expected no beat",
                             d, m_tlast[d], m_tdata[d]);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    if ({m_tlast[d], m_tdata[d]} !== e) begin
                        errors++;
                        $display("FAIL beat_data dut%0d: got last=%b data=%h, expected last=%b data=%h",
                                 d, m_tlast[d], m_tdata[d], e[32], e[31:0]);
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_frame(input int d, input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            s_tdata[d]  = base + k;
            s_tlast[d]  = (k == n - 1);
            s_tvalid[d] = 1'b1;
            while (!s_tready[d] && t < 100) begin
                cyc();
                t++;
            end
            if (!s_tready[d]) begin
                errors++;
                checks++;
                $display("FAIL send_timeout dut%0d: word %0d not accepted in 100 cycles", d, k);
            end
            cyc();
        end
        s_tvalid[d] = 1'b0;
        s_tlast[d]  = 1'b0;
    endtask

    // Act as the core for one job (frame already sent) and collect the results.
    task automatic finish_job(input int d, input logic [31:0] base, input logic [31:0] status, input bit toggle);
        int t = 0;
        int b0;
        int bad = 0;
        logic [NO*DW-1:0] res;
        while (!core_start[d] && t < 50) begin
            cyc();
            t++;
        end
        checks++;
        if (core_start[d] !== 1'b1) begin
            errors++;
            $display("FAIL start_timeout dut%0d: core_start=%b, expected 1", d, core_start[d]);
        end
        for (int k = 0; k < NI; k++)
            if (core_in[d][(NI - 1 - k) * DW +: DW] !== base + k) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL core_in_words dut%0d: %0d words wrong, expected 0", d, bad);
        end
        checks++;
        if (s_tready[d] !== 1'b0) begin
            errors++;
            $display("FAIL tready_proc dut%0d: got %b, expected 0", d, s_tready[d]);
        end
        for (int i = 0; i < NO; i++) begin
            res[(NO - 1 - i) * DW +: DW] = 32'h11111111 * (i + 1) + base;
            push(d, 32'h11111111 * (i + 1) + base, (i == NO - 1) && (d == 0));
        end
        if (d == 1) push(d, status, 1'b1);
        b0 = beats[d];
        core_out[d]  = res;
        core_done[d] = 1'b1;
        cyc();
        core_done[d] = 1'b0;
        checks++;
        if (m_tvalid[d] !== 1'b1) begin
            errors++;
            $display("FAIL done_latency dut%0d: m_tvalid=%b one cycle after core_done, expected 1", d, m_tvalid[d]);
        end
        t = 0;
        while ((m_tvalid[d] || qsize(d) > 0) && t < 200) begin
            m_tready[d] = toggle ? t[0] : 1'b1;
            cyc();
            t++;
        end
        m_tready[d] = 1'b1;
        checks++;
        if (beats[d] - b0 != NO + d) begin
            errors++;
            $display("FAIL beat_count dut%0d: got %0d, expected %0d", d, beats[d] - b0, NO + d);
        end
        checks++;
        if (s_tready[d] !== 1'b1) begin
            errors++;
            $display("FAIL tready_after_send dut%0d: got %b, expected 1", d, s_tready[d]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({s_tready[d], m_tvalid[d], m_tlast[d], core_start[d], err_short[d], err_long[d], err_count[d]}
                !== {6'b100000, 8'd0}) begin
                errors++;
                $display("FAIL reset_state dut%0d: tready/tvalid/tlast/start/short/long=%b%b%b%b%b%b cnt=%0d, expected 100000 cnt=0",
                         d, s_tready[d], m_tvalid[d], m_tlast[d], core_start[d], err_short[d], err_long[d], err_count[d]);
            end
        end
        checks++;
        if (m_tkeep[0] !== 4'hF) begin
            errors++;
            $display("FAIL tkeep: got %h, expected f", m_tkeep[0]);
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_exact_frame();
        int s0 = starts[0];
        send_frame(0, NI, 32'd0);
        checks++;
        if (core_in[0][639:608] !== 32'd0 || core_in[0][31:0] !== 32'd19) begin
            errors++;
            $display("FAIL core_in_ends: got first=%h last=%h, expected 0 and 13", core_in[0][639:608], core_in[0][31:0]);
        end
        finish_job(0, 32'd0, 32'd0, 1'b1);
        checks++;
        if (starts[0] - s0 != 1) begin
            errors++;
            $display("FAIL start_pulses: got %0d cycles high, expected 1", starts[0] - s0);
        end
    endtask

    task automatic test_short();
        int s0 = starts[0];
        send_frame(0, 5, 32'h100);
        checks++;
        if (err_short[0] !== 1'b1 || err_count[0] !== 8'd1 || s_tready[0] !== 1'b1) begin
            errors++;
            $display("FAIL short5: err_short=%b cnt=%0d tready=%b, expected 1 1 1", err_short[0], err_count[0], s_tready[0]);
        end
        cyc();
        checks++;
        if (err_short[0] !== 1'b0) begin
            errors++;
            $display("FAIL short_pulse_width: err_short=%b, expected 0", err_short[0]);
        end
        send_frame(0, 1, 32'h200);
        checks++;
        if (err_short[0] !== 1'b1 || err_count[0] !== 8'd2) begin
            errors++;
            $display("FAIL short1: err_short=%b cnt=%0d, expected 1 2", err_short[0], err_count[0]);
        end
        repeat (5) cyc();
        checks++;
        if (starts[0] != s0) begin
            errors++;
            $display("FAIL short_no_start: got %0d starts, expected 0", starts[0] - s0);
        end
        send_frame(0, NI, 32'h300);
        finish_job(0, 32'h300, 32'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        send_frame(0, NI, 32'h1000);
        finish_job(0, 32'h1000, 32'd0, 1'b0);
        send_frame(0, NI, 32'h2000);
        finish_job(0, 32'h2000, 32'd0, 1'b0);
    endtask

    task automatic test_reset_in_send();
        int b0;
        logic [31:0] d0;
        logic [NO*DW-1:0] res;
        send_frame(0, NI, 32'h4000);
        if (!core_start[0]) cyc();
        for (int i = 0; i < NO; i++) begin
            res[(NO - 1 - i) * DW +: DW] = 32'hA0000000 + i;
            push(0, 32'hA0000000 + i, i == NO - 1);
        end
        b0 = beats[0];
        m_tready[0]  = 1'b0;
        core_out[0]  = res;
        core_done[0] = 1'b1;
        cyc();
        core_done[0] = 1'b0;
        d0 = m_tdata[0];
        cyc();
        cyc();
        checks++;
        if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== d0 || d0 !== 32'hA0000000) begin
            errors++;
            $display("FAIL hold_stall: tvalid=%b data=%h first=%h, expected 1 a0000000 a0000000", m_tvalid[0], m_tdata[0], d0);
        end
        m_tready[0] = 1'b1;
        repeat (3) cyc();
        m_tready[0] = 1'b0;
        reset = 1'b1;
        cyc();
        checks++;
        if (m_tvalid[0] !== 1'b0 || m_tlast[0] !== 1'b0 || err_count[0] !== 8'd0 || s_tready[0] !== 1'b1
            || beats[0] - b0 != 3) begin
            errors++;
            $display("FAIL reset_in_send: tvalid=%b tlast=%b cnt=%0d tready=%b beats=%0d, expected 0 0 0 1 3",
                     m_tvalid[0], m_tlast[0], err_count[0], s_tready[0], beats[0] - b0);
        end
        q0.delete();
        q1.delete();
        reset = 1'b0;
        m_tready[0] = 1'b1;
        cyc();
        send_frame(0, NI, 32'h5000);
        finish_job(0, 32'h5000, 32'd0, 1'b1);
    endtask

    task automatic test_long_status();
        send_frame(1, NI + 3, 32'h6000);
        checks++;
        if (err_long[1] !== 1'b1 || err_count[1] !== 8'd1 || core_start[1] !== 1'b1) begin
            errors++;
            $display("FAIL long_frame: err_long=%b cnt=%0d start=%b, expected 1 1 1", err_long[1], err_count[1], core_start[1]);
        end
        finish_job(1, 32'h6000, 32'h00000001, 1'b1);
        send_frame(1, NI, 32'h7000);
        finish_job(1, 32'h7000, 32'h00010000, 1'b0);
    endtask

    task automatic test_saturate();
        int b0 = beats[0];
        int s0 = starts[0];
        int vbad = 0;
        for (int i = 0; i < 300; i++) send_frame(0, 1, i);
        checks++;
        if (err_count[0] !== 8'd255) begin
            errors++;
            $display("FAIL err_saturate: got %0d, expected 255", err_count[0]);
        end
        for (int i = 0; i < 3; i++) begin
            core_done[0] = 1'b1;
            cyc();
            core_done[0] = 1'b0;
            if (m_tvalid[0] !== 1'b0) vbad++;
            cyc();
        end
        repeat (10) begin
            if (m_tvalid[0] !== 1'b0) vbad++;
            cyc();
        end
        checks++;
        if (vbad != 0 || beats[0] != b0 || starts[0] != s0) begin
            errors++;
            $display("FAIL idle_done_ignored: valid cycles=%0d beats=%0d starts=%0d, expected 0 0 0",
                     vbad, beats[0] - b0, starts[0] - s0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            s_tdata[d]  = '0;
            core_out[d] = '0;
            beats[d]    = 0;
            starts[d]   = 0;
        end
        s_tvalid  = '0;
        s_tlast   = '0;
        m_tready  = '1;
        core_done = '0;
        @(negedge clk);
        test_reset();
        test_exact_frame();
        test_short();
        test_back_to_back();
        test_reset_in_send();
        test_long_status();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axis_core_wrapper.md
AXIS_CORE_WRAPPER -- requirements
Module: axis_core_wrapper

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset respectively.
REQ-002 The block SHALL take these parameters (name, default, meaning):
- DATA_W, 32, stream word width; legal values are >=32 and a multiple of 8.
- IN_WORDS, 20, words per input job; legal range 2..256.
- OUT_WORDS, 8, result words per job; legal range 1..256.
- STATUS_EN, 0, when 1, append one status word after the result words.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, sync active-high reset.
- s_axis_tdata, in, DATA_W, input word.
- s_axis_tvalid, in, 1, input valid.
- s_axis_tlast, in, 1, last input word.
- s_axis_tready, out, 1, input ready.
- m_axis_tdata, out, DATA_W, output word.
- m_axis_tkeep, out, DATA_W/8, output byte enables, constant all-ones.
- m_axis_tvalid, out, 1, output valid.
- m_axis_tlast, out, 1, last output word.
- m_axis_tready, in, 1, output ready.
- core_start, out, 1, one-cycle start pulse to the core.
- core_in, out, IN_WORDS*DATA_W, job words; word 0 in the MSBs.
- core_done, in, 1, one-cycle result-valid pulse from the core.
- core_out, in, OUT_WORDS*DATA_W, results; word 0 in the MSBs.
- err_short, out, 1, one-cycle pulse when a frame was short.
- err_long, out, 1, one-cycle pulse when a frame was long.
- err_count, out, 8, saturating count of short+long errors.

Function
REQ-004 The FSM SHALL have the states IDLE, RECV, DRAIN, PROC and SEND.
REQ-005 s_axis_tready SHALL be 1 in IDLE, RECV and DRAIN, and 0 in PROC and SEND.
REQ-006 An input beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both 1; accepted word n (counted from 0) SHALL be stored at index n.
REQ-007 IDLE SHALL go to RECV on an accepted beat that does not carry tlast.
REQ-008 Short frame: a beat accepted with tlast at index < IN_WORDS-1 (including index 0 in IDLE) SHALL:
- discard the job;
- pulse err_short for one cycle;
- increment err_count;
- put the FSM in IDLE on the next cycle;
- not assert core_start.
REQ-009 Exact frame: the beat at index IN_WORDS-1 accepted with tlast SHALL move the FSM to PROC.
REQ-010 Long frame, part 1: the beat at index IN_WORDS-1 accepted without tlast SHALL move the FSM to DRAIN.
REQ-011 Long frame, part 2: in DRAIN, beats SHALL be accepted and dropped until a tlast beat; that beat SHALL:
- pulse err_long;
- increment err_count;
- set the internal long_flag;
- move the FSM to PROC.
REQ-012 core_start SHALL be high for exactly the first cycle of PROC; core_in SHALL stay stable from that cycle until SEND is left.
REQ-013 On core_done in PROC, core_out SHALL be captured into the output buffer and the FSM SHALL enter SEND on the next cycle; core_done outside PROC SHALL be ignored.
REQ-014 In SEND, m_axis_tvalid SHALL be 1 and m_axis_tdata SHALL present buffer word rd_ptr, with rd_ptr starting at 0.
REQ-015 rd_ptr SHALL advance only on an m_axis_tvalid && m_axis_tready handshake; data and valid SHALL hold while tready is 0.
REQ-016 The total output beat count SHALL be OUT_WORDS+STATUS_EN; m_axis_tlast SHALL be 1 only on the final beat.
REQ-017 The status word SHALL be: bits[31:16] = job_id, bit[0] = long_flag, all other bits 0.
REQ-018 job_id SHALL be a 16-bit counter that increments on every core_start and wraps 0xFFFF→0x0000.
REQ-019 The handshake on the final beat SHALL:
- return the FSM to IDLE;
- clear rd_ptr and long_flag;
- make s_axis_tready 1 on the following cycle.
REQ-020 err_count SHALL saturate at 255; a simultaneous err_short/err_long condition is impossible and needs no handling.
REQ-021 All counters SHALL be sized as clog2 of their range, and no counter SHALL wrap except job_id.
REQ-022 Output beat latency SHALL be 1 cycle from the core_done edge to m_axis_tvalid=1.

Reset
REQ-023 When reset is asserted in any state, including mid-frame, PROC and SEND, the block SHALL on the next edge:
- enter IDLE;
- set err_count, job_id, rd_ptr and the write index to 0;
- drive core_start, m_axis_tvalid, m_axis_tlast, err_short and err_long to 0;
- set s_axis_tready to 1 after reset deasserts.
REQ-024 Input and output buffer contents SHALL NOT be cleared by reset, and m_axis_tdata SHALL be don't-care while m_axis_tvalid is 0.

Verification
REQ-025 Default parameters, 20-word frame (word k = k), tlast on word 19 → one core_start pulse; core_in[639:608]=0, core_in[31:0]=19.
REQ-026 Core returns 0x11111111..0x88888888 and m_axis_tready toggles 1/0 → 8 beats in order; tlast on 0x88888888 only; no beat lost or duplicated.
REQ-027 5-word frame with tlast on word 4 → err_short pulse, err_count=1, no core_start, s_axis_tready stays 1; the next 20-word frame processes normally.
REQ-028 STATUS_EN=1, 23-word frame → err_long, then 9 output beats; 9th beat = 0x00000001 (job_id 0, long_flag 1); the second job's status word = 0x00010000.
REQ-029 Reset asserted in SEND after 3 beats → next cycle m_axis_tvalid=0, FSM in IDLE, err_count=0; a fresh job afterwards starts at rd_ptr 0.
REQ-030 300 short frames → err_count saturates at 255; core_done pulses injected in IDLE → no output beats.
